cnn_result_reader: RTL and testbench

- Read-side partner of the 4x4 cellular-network array. It watches the array's 16 signed 9-bit outputs Y1..Y16 after a run is started.
- It decides when the outputs have settled, or when a timeout has expired.
- It then freezes a snapshot of the outputs and streams the 16 values out one per transfer over a valid/ready port, for a host or DMA block to collect.

---
 rtl/cnn_pkg.sv | 16 +
 rtl/cnn_result_reader_if.sv | 14 +
 rtl/cnn_settle_detect.sv | 47 ++++
 rtl/cnn_result_reader.sv | 134 +++++++++++++
 tb/tb_cnn_result_reader.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the cellular-network result reader.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cnn_pkg;
  localparam int Y_W     = 9;
  localparam int N_CELLS = 16;
  localparam int IDX_W   = 4;

  typedef enum logic [1:0] {IDLE, SETTLE, STREAM, DONE} state_t;

  // Pick cell k out of the flattened array bus (cell k sits at [Y_W*k +: Y_W]).
  function automatic logic signed [Y_W-1:0] cell_of(input logic [N_CELLS*Y_W-1:0] bus,
                                                    input logic [IDX_W-1:0] k);
    return bus[int'(k)*Y_W +: Y_W];
  endfunction
endpackage

// File: rtl/cnn_result_reader_if.sv
// Stream port carrying one snapshot cell per transfer.
// Latency: none (wiring only).
// Backpressure: consumer stalls the producer by holding out_ready low.
interface cnn_result_reader_if;
  import cnn_pkg::*;
  logic signed [Y_W-1:0] out_data;
  logic [IDX_W-1:0]      out_idx;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (output out_data, out_idx, out_valid, out_last, input out_ready);
  modport slave  (input out_data, out_idx, out_valid, out_last, output out_ready);
endinterface

// File: rtl/cnn_settle_detect.sv
// Tracks how long the array outputs have been unchanged and how long the run has settled.
// Latency: converge/timeout are combinational on the current compare, counters update each cycle.
// Backpressure: none; counts only while i_en is high.
module cnn_settle_detect
  import cnn_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 1024,
  parameter int CNT_W         = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clear,
  input  logic                     i_en,
  input  logic [N_CELLS*Y_W-1:0]   i_y,
  output logic                     o_converge,
  output logic                     o_timeout,
  output logic [CNT_W-1:0]         o_cyc_cnt
);
  logic [N_CELLS*Y_W-1:0] r_y_prev;
  logic [3:0]             r_stable_cnt;
  logic [CNT_W-1:0]       r_cyc_cnt;
  logic                   w_eq;

  assign w_eq       = (i_y == r_y_prev);
  // Convergence wins over timeout in the parent, so both may be flagged together.
  assign o_converge = w_eq && (r_stable_cnt == 4'(STABLE_CYCLES - 1));
  assign o_timeout  = (r_cyc_cnt == CNT_W'(TIMEOUT - 1));
  assign o_cyc_cnt  = r_cyc_cnt;

  // Load the baseline on start, then compare against the previous sample every settle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_prev     <= '0;
      r_stable_cnt <= '0;
      r_cyc_cnt    <= '0;
    end else if (i_clear) begin
      r_y_prev     <= i_y;
      r_stable_cnt <= '0;
      r_cyc_cnt    <= '0;
    end else if (i_en) begin
      r_y_prev     <= i_y;
      r_stable_cnt <= w_eq ? r_stable_cnt + 4'd1 : 4'd0;
      r_cyc_cnt    <= r_cyc_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/cnn_result_reader.sv
// Waits for the cell array to settle (or time out), snapshots it and streams the 16 cells out.
// Latency: out_valid rises STABLE_CYCLES+1 cycles after start with a constant array.
// Backpressure: out_data/out_idx hold while out_valid && !out_ready; the snapshot ignores later inputs.
module cnn_result_reader
  import cnn_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 1024,
  parameter int CNT_W         = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [N_CELLS*Y_W-1:0] y_in,
  cnn_result_reader_if.master    m_out,
  output logic                   busy,
  output logic                   done,
  output logic                   timed_out,
  output logic [CNT_W-1:0]       settle_cycles
);
  state_t                 r_state;
  logic [N_CELLS*Y_W-1:0] r_buf;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_valid;
  logic                   r_last;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_timed_out;
  logic [CNT_W-1:0]       r_settle_cycles;

  logic                   w_start_go;
  logic                   w_converge;
  logic                   w_timeout;
  logic [CNT_W-1:0]       w_cyc_cnt;

  assign w_start_go = (r_state == IDLE) && start && !abort;

  cnn_settle_detect #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .TIMEOUT       (TIMEOUT),
    .CNT_W         (CNT_W)
  ) u_detect (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_start_go),
    .i_en       (r_state == SETTLE),
    .i_y        (y_in),
    .o_converge (w_converge),
    .o_timeout  (w_timeout),
    .o_cyc_cnt  (w_cyc_cnt)
  );

  assign m_out.out_data  = cell_of(r_buf, r_idx);
  assign m_out.out_idx   = r_idx;
  assign m_out.out_valid = r_valid;
  assign m_out.out_last  = r_last;
  assign busy            = r_busy;
  assign done            = r_done;
  assign timed_out       = r_timed_out;
  assign settle_cycles   = r_settle_cycles;

  // Run controller: settle, snapshot, stream with registered handshake outputs; abort overrides all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_buf           <= '0;
      r_idx           <= '0;
      r_valid         <= 1'b0;
      r_last          <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_timed_out     <= 1'b0;
      r_settle_cycles <= '0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state <= IDLE;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
        r_busy  <= 1'b0;
        r_idx   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_state         <= SETTLE;
              r_busy          <= 1'b1;
              r_timed_out     <= 1'b0;
              r_settle_cycles <= '0;
            end
          end
          SETTLE: begin
            if (w_converge) begin
              r_buf           <= y_in;
              r_settle_cycles <= w_cyc_cnt + CNT_W'(1);
              r_state         <= STREAM;
              r_valid         <= 1'b1;
              r_last          <= (N_CELLS == 1);
              r_idx           <= '0;
            end else if (w_timeout) begin
              r_buf           <= y_in;
              r_timed_out     <= 1'b1;
              r_settle_cycles <= CNT_W'(TIMEOUT);
              r_state         <= STREAM;
              r_valid         <= 1'b1;
              r_last          <= (N_CELLS == 1);
              r_idx           <= '0;
            end
          end
          STREAM: begin
            if (r_valid && m_out.out_ready) begin
              if (r_last) begin
                r_state <= DONE;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_idx   <= '0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_idx  <= r_idx + IDX_W'(1);
                r_last <= (r_idx == IDX_W'(N_CELLS - 2));
              end
            end
          end
          DONE: begin
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cnn_result_reader.sv
// Directed bench for the result reader: latency, timeout, backpressure, abort, reset.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: out_ready driven from a fixed pattern in the stall test.
module tb_cnn_result_reader;
  logic         clk;
  logic         rst_n;
  logic         start, abort, start1, abort1;
  logic [143:0] y_in;
  logic         busy, done, timed_out;
  logic [9:0]   settle_cycles;
  logic         busy1, done1, timed_out1;
  logic [9:0]   settle_cycles1;

  int total = 0;
  int bad   = 0;
  int n;
  int exp_b;
  int exp_snap[16];
  bit pat[4];

  cnn_result_reader_if if0();
  cnn_result_reader_if if1();

  cnn_result_reader #(.STABLE_CYCLES(4), .TIMEOUT(16), .CNT_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .y_in(y_in),
    .m_out(if0), .busy(busy), .done(done), .timed_out(timed_out),
    .settle_cycles(settle_cycles)
  );

  cnn_result_reader #(.STABLE_CYCLES(1), .TIMEOUT(16), .CNT_W(10)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .y_in(y_in),
    .m_out(if1), .busy(busy1), .done(done1), .timed_out(timed_out1),
    .settle_cycles(settle_cycles1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ramp(input int off);
    for (int k = 0; k < 16; k++) y_in[9*k +: 9] = 9'(k + off);
  endtask

  task automatic wait_vld(output int cnt);
    cnt = 0;
    while (!if0.out_valid && cnt < 60) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; start1 = 1'b0; abort1 = 1'b0;
    if0.out_ready = 1'b0; if1.out_ready = 1'b1;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    set_ramp(-8);
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_valid", if0.out_valid, 0);
    chk("rst_idx", if0.out_idx, 0);
    chk("rst_data", if0.out_data, 0);
    chk("rst_last", if0.out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_to", timed_out, 0);
    chk("rst_settle", settle_cycles, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();

    // Constant ramp -8..7: converge after 4 compares, full stream, done pulse.
    if0.out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    wait_vld(n);
    chk("lat4", n, 4);
    chk("t1_settle", settle_cycles, 4);
    chk("t1_to", timed_out, 0);
    chk("t1_busy", busy, 1);
    for (int b = 0; b < 16; b++) begin
      chk("t1_idx", if0.out_idx, b);
      chk("t1_data", if0.out_data, b - 8);
      chk("t1_last", if0.out_last, (b == 15) ? 1 : 0);
      tick();
    end
    chk("t1_done", done, 1);
    chk("t1_vld_off", if0.out_valid, 0);
    chk("t1_busy_off", busy, 0);
    tick();
    chk("t1_done_pulse", done, 0);

    // Cell 3 toggles every cycle: forced snapshot after 16 settle cycles.
    set_ramp(20);
    y_in[27 +: 9] = 9'h0FF;
    for (int k = 0; k < 16; k++) exp_snap[k] = k + 20;
    exp_snap[3] = 255;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      y_in[27 +: 9] = (i % 2 == 1) ? 9'h100 : 9'h0FF;
      tick();
      if (i == 15) chk("to_early", if0.out_valid, 0);
    end
    chk("to_vld", if0.out_valid, 1);
    chk("to_flag", timed_out, 1);
    chk("to_settle", settle_cycles, 16);
    set_ramp(-100);

    // Stall pattern 1,0,0,1 while the array keeps changing.
    exp_b = 0;
    n = 0;
    while (exp_b < 16 && n < 200) begin
      if0.out_ready = pat[n % 4];
      chk("bp_vld", if0.out_valid, 1);
      chk("bp_idx", if0.out_idx, exp_b);
      chk("bp_data", if0.out_data, exp_snap[exp_b % 16]);
      if (if0.out_valid && if0.out_ready) exp_b++;
      y_in[8:0] = 9'(n * 7);
      tick();
      n++;
    end
    chk("bp_beats", exp_b, 16);
    chk("bp_done", done, 1);
    if0.out_ready = 1'b1;
    tick();

    // Changes on settle cycles 1 and 3, converge on cycle 7.
    set_ramp(0);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      if (i == 1) set_ramp(1);
      if (i == 3) set_ramp(2);
      tick();
      chk("cv_vld", if0.out_valid, (i == 7) ? 1 : 0);
    end
    chk("cv_settle", settle_cycles, 7);
    chk("cv_to_clr", timed_out, 0);

    // Abort on beat 5.
    for (int b = 0; b < 5; b++) tick();
    chk("ab_idx5", if0.out_idx, 5);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("ab_vld", if0.out_valid, 0);
    chk("ab_idx", if0.out_idx, 0);
    chk("ab_busy", busy, 0);
    chk("ab_settle", settle_cycles, 7);
    tick();
    chk("ab_nodone", done, 0);

    // Restart; a start during SETTLE must not restart the count.
    start = 1'b1; tick(); start = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_vld(n);
    chk("rs_lat", n, 2);
    chk("rs_idx", if0.out_idx, 0);
    chk("rs_data", if0.out_data, 2);
    tick(); tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("rs_ign_idx", if0.out_idx, 4);
    chk("rs_ign_busy", busy, 1);

    // Async reset mid-stream.
    rst_n = 1'b0; #2;
    chk("ar_vld", if0.out_valid, 0);
    chk("ar_idx", if0.out_idx, 0);
    chk("ar_data", if0.out_data, 0);
    chk("ar_busy", busy, 0);
    chk("ar_settle", settle_cycles, 0);
    rst_n = 1'b1;
    tick();

    // Async reset mid-settle; nothing resumes afterwards.
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    rst_n = 1'b0; #2;
    chk("as_busy", busy, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("as_noresume", if0.out_valid, 0);

    // STABLE_CYCLES=1 instance: out_valid two cycles after start.
    set_ramp(5);
    start1 = 1'b1; tick(); start1 = 1'b0;
    chk("s1_early", if1.out_valid, 0);
    tick();
    chk("s1_vld", if1.out_valid, 1);
    chk("s1_settle", settle_cycles1, 1);
    chk("s1_data", if1.out_data, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
